mioc_mem_seq: RTL

Parametrised successor to the MIOC memory-control section. It generates the DRAM RAS/MUX/CAS strobe sequence with programmable phase lengths, and supports NUM_CAS DRAM banks instead of a fixed two. It also holds a write-loadable memory-map register, latched from BD on an I/O write, that steers each access to the boot ROM, the aux ROM or a RAM bank. It sits between the buffered Z80 bus (BMREQ_N, BRFSH_N, IORQ_N, N_BWR, BA, BD) and the DRAM and ROM chip selects.

---
 rtl/mioc_mem_seq_if.sv | 31 +++
 rtl/mioc_mem_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mioc_mem_seq_if.sv
// Buffered Z80 bus plus DRAM/ROM strobe bundle for the MIOC memory sequencer.
// The master side drives the bus; the slave side is the sequencer.
interface mioc_mem_seq_if #(
    parameter int NUM_CAS  = 2,
    parameter int MAP_BITS = 4
);
    logic                BMREQ_N;
    logic                BRFSH_N;
    logic                IORQ_N;
    logic                N_BWR;
    logic [15:0]         BA;
    logic [MAP_BITS-1:0] BD;

    logic                RAS_N;
    logic                MUX;
    logic [NUM_CAS-1:0]  CAS_N;
    logic                BOOTROMCS_N;
    logic                AUXROMCS_N;
    logic [MAP_BITS-1:0] MAP_Q;
    logic                BUSY;

    modport master (
        output BMREQ_N, BRFSH_N, IORQ_N, N_BWR, BA, BD,
        input  RAS_N, MUX, CAS_N, BOOTROMCS_N, AUXROMCS_N, MAP_Q, BUSY
    );

    modport slave (
        input  BMREQ_N, BRFSH_N, IORQ_N, N_BWR, BA, BD,
        output RAS_N, MUX, CAS_N, BOOTROMCS_N, AUXROMCS_N, MAP_Q, BUSY
    );
endinterface

// File: rtl/mioc_mem_seq.sv
// MIOC memory sequencer: RAS/MUX/CAS strobe timing for NUM_CAS DRAM banks,
// ROM chip selects, and the I/O-writable memory-map register.
//
// state | meaning
// IDLE  | waiting for a memory request
// ROW   | RAS low, row address on the mux
// COL   | RAS low, column address on the mux
// ACT   | CAS or ROM select asserted for the latched target
// REF   | RAS-only refresh
// PRE   | precharge, all strobes inactive
module mioc_mem_seq #(
    parameter int         NUM_CAS   = 2,
    parameter int         MAP_BITS  = 4,
    parameter logic [7:0] MAP_PORT  = 8'h7F,
    parameter int         T_RAS_MUX = 1,
    parameter int         T_MUX_CAS = 1,
    parameter int         T_CAS_MIN = 2,
    parameter int         T_PRE     = 2,
    parameter int         T_REF     = 3
) (
    input logic           B_PHI,
    input logic           RST_N,
    mioc_mem_seq_if.slave bus
);

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int T_MAX = imax(imax(imax(T_RAS_MUX, T_MUX_CAS), imax(T_CAS_MIN, T_PRE)), T_REF);
    localparam int CNT_W = $clog2(T_MAX) + 1;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef enum logic [2:0] {S_IDLE, S_ROW, S_COL, S_ACT, S_REF, S_PRE} state_t;
    typedef enum logic [1:0] {TGT_NONE, TGT_BOOT, TGT_AUX, TGT_BANK} tgt_t;

    state_t              state, state_nxt;
    cnt_t                cnt, cnt_nxt;
    tgt_t                tgt, tgt_nxt, tgt_dec;
    logic [1:0]          bank, bank_nxt, bank_dec;
    logic                ras_nxt, mux_nxt, boot_nxt, aux_nxt, act_nxt;
    logic [NUM_CAS-1:0]  cas_nxt;
    logic                map_wr;
    logic [MAP_BITS-1:0] map_q;
    logic                unused_ba;

    assign map_wr    = !bus.IORQ_N && !bus.N_BWR && (bus.BA[7:0] == MAP_PORT);
    assign unused_ba = ^bus.BA[14:8];

    // Decode always sees the pre-write map, so a same-edge write cannot steer this access.
    always_comb begin
        tgt_dec  = TGT_NONE;
        bank_dec = 2'd0;
        if (!bus.BA[15]) begin
            case (map_q[1:0])
                2'b00: tgt_dec = TGT_BOOT;
                2'b01: tgt_dec = TGT_BANK;
                2'b10: tgt_dec = TGT_AUX;
                default: begin
                    if (NUM_CAS > 1) begin
                        tgt_dec  = TGT_BANK;
                        bank_dec = 2'd1;
                    end
                end
            endcase
        end else if (int'(map_q[3:2]) < NUM_CAS) begin
            tgt_dec  = TGT_BANK;
            bank_dec = map_q[3:2];
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tgt_nxt   = tgt;
        bank_nxt  = bank;
        case (state)
            S_IDLE: begin
                if (!bus.BMREQ_N && !bus.BRFSH_N) begin
                    state_nxt = S_REF;
                    cnt_nxt   = cnt_t'(T_REF - 1);
                end else if (!bus.BMREQ_N) begin
                    state_nxt = S_ROW;
                    cnt_nxt   = cnt_t'(T_RAS_MUX - 1);
                    tgt_nxt   = tgt_dec;
                    bank_nxt  = bank_dec;
                end
            end
            S_ROW: begin
                if (bus.BMREQ_N) begin
                    state_nxt = S_PRE;
                    cnt_nxt   = cnt_t'(T_PRE - 1);
                end else if (cnt == '0) begin
                    state_nxt = S_COL;
                    cnt_nxt   = cnt_t'(T_MUX_CAS - 1);
                end else begin
                    cnt_nxt = cnt - cnt_t'(1);
                end
            end
            S_COL: begin
                if (bus.BMREQ_N) begin
                    state_nxt = S_PRE;
                    cnt_nxt   = cnt_t'(T_PRE - 1);
                end else if (cnt == '0) begin
                    state_nxt = S_ACT;
                    cnt_nxt   = cnt_t'(T_CAS_MIN - 1);
                end else begin
                    cnt_nxt = cnt - cnt_t'(1);
                end
            end
            S_ACT: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - cnt_t'(1);
                end else if (bus.BMREQ_N) begin
                    state_nxt = S_PRE;
                    cnt_nxt   = cnt_t'(T_PRE - 1);
                end
            end
            S_REF: begin
                if (cnt == '0) begin
                    state_nxt = S_PRE;
                    cnt_nxt   = cnt_t'(T_PRE - 1);
                end else begin
                    cnt_nxt = cnt - cnt_t'(1);
                end
            end
            S_PRE: begin
                if (cnt == '0) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - cnt_t'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Strobes are derived from the next state so that they register together with it.
    always_comb begin
        ras_nxt  = !(state_nxt inside {S_ROW, S_COL, S_ACT, S_REF});
        mux_nxt  = state_nxt inside {S_COL, S_ACT};
        act_nxt  = (state_nxt == S_ACT);
        boot_nxt = !(act_nxt && tgt_nxt == TGT_BOOT);
        aux_nxt  = !(act_nxt && tgt_nxt == TGT_AUX);
        cas_nxt  = '1;
        for (int i = 0; i < NUM_CAS; i++) begin
            cas_nxt[i] = !(act_nxt && tgt_nxt == TGT_BANK && int'(bank_nxt) == i);
        end
    end

    always_ff @(posedge B_PHI or negedge RST_N) begin
        if (!RST_N) begin
            state           <= S_IDLE;
            cnt             <= '0;
            tgt             <= TGT_NONE;
            bank            <= 2'd0;
            map_q           <= '0;
            bus.RAS_N       <= 1'b1;
            bus.MUX         <= 1'b0;
            bus.CAS_N       <= '1;
            bus.BOOTROMCS_N <= 1'b1;
            bus.AUXROMCS_N  <= 1'b1;
            bus.BUSY        <= 1'b0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            tgt             <= tgt_nxt;
            bank            <= bank_nxt;
            if (map_wr) begin
                map_q <= bus.BD;
            end
            bus.RAS_N       <= ras_nxt;
            bus.MUX         <= mux_nxt;
            bus.CAS_N       <= cas_nxt;
            bus.BOOTROMCS_N <= boot_nxt;
            bus.AUXROMCS_N  <= aux_nxt;
            bus.BUSY        <= (state_nxt != S_IDLE);
        end
    end

    assign bus.MAP_Q = map_q;

endmodule
